seg_scan_decoder: RTL and testbench

//  Receive-side counterpart of the stopwatch seven-segment display driver.

---
 rtl/seg_scan_decoder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: readback monitor for a multiplexed 4-digit seven-segment bus.
// Samples the active-low anode/cathode lines, waits for each digit slot to hold
// steady, decodes the segment pattern back to BCD and rebuilds the MM:SS frame.
// Optional blink detection is compiled in when BLINK_DETECT_EN is defined;
// without it, blinking is tied low and no blink logic exists.
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned BLINK_WIN  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  anode_vec,
  input  logic [7:0]  cathode_vec,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  blank,
  output logic        frame_done,
  output logic        err_seg,
  output logic        err_anode,
  output logic [3:0]  blinking
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

  // Number of anode lines driven low (active digits).
  function automatic logic [2:0] low_count(input logic [3:0] a);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, ~a[i]};
    return n;
  endfunction

  // Slot index of a one-hot-low anode word.
  function automatic logic [1:0] slot_of(input logic [3:0] a);
    case (a)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Segment pattern (active-high, g..a) to {hit, bcd}.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h3F:   return {1'b1, 4'd0};
      7'h06:   return {1'b1, 4'd1};
      7'h5B:   return {1'b1, 4'd2};
      7'h4F:   return {1'b1, 4'd3};
      7'h66:   return {1'b1, 4'd4};
      7'h6D:   return {1'b1, 4'd5};
      7'h7D:   return {1'b1, 4'd6};
      7'h07:   return {1'b1, 4'd7};
      7'h7F:   return {1'b1, 4'd8};
      7'h6F:   return {1'b1, 4'd9};
      default: return {1'b0, 4'd0};
    endcase
  endfunction

  logic [3:0]    anode_q, anode_prev_q;
  logic [6:0]    cath_q, cath_prev_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   digits_q, digits_d;
  logic [3:0]    valid_q, valid_d, blank_q, blank_d, mask_q, mask_d, mask_new_s;
  logic          frame_done_q, frame_done_d, err_seg_q, err_seg_d, err_anode_q, err_anode_d;
  logic          one_hot_s, multi_s, prev_multi_s, in_chg_s, anode_chg_s;
  logic          cap_s, cap_blank_s;
  logic [1:0]    cap_slot_s;
  logic [6:0]    cap_seg_s;
  logic [4:0]    cap_dec_s;
  logic          dp_unused_s;

  assign dp_unused_s  = cathode_vec[7];
  assign one_hot_s    = (low_count(anode_q) == 3'd1);
  assign multi_s      = (low_count(anode_q) > 3'd1);
  assign prev_multi_s = (low_count(anode_prev_q) > 3'd1);
  assign in_chg_s     = ({anode_q, cath_q} != {anode_prev_q, cath_prev_q});
  assign anode_chg_s  = (anode_q != anode_prev_q);

  // In CAPTURE the previous sample is the value that was proven stable in SETTLE.
  assign cap_s       = (state_q == ST_CAPTURE);
  assign cap_seg_s   = ~cath_prev_q;
  assign cap_dec_s   = seg_decode(cap_seg_s);
  assign cap_blank_s = (cap_seg_s == 7'h00);
  assign cap_slot_s  = slot_of(anode_prev_q);
  assign mask_new_s  = mask_q | (4'b0001 << cap_slot_s);

  // Input stage plus one-cycle-delayed copy used for change detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anode_q      <= 4'hF;
      cath_q       <= 7'h7F;
      anode_prev_q <= 4'hF;
      cath_prev_q  <= 7'h7F;
    end else begin
      anode_q      <= anode_vec;
      cath_q       <= cathode_vec[6:0];
      anode_prev_q <= anode_q;
      cath_prev_q  <= cath_q;
    end
  end

  // Scan FSM next-state and settle counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = {CW{1'b0}};
        if (one_hot_s) state_d = ST_SETTLE;
        else           state_d = ST_IDLE;
      end
      ST_SETTLE: begin
        if (in_chg_s) begin
          cnt_d = {CW{1'b0}};
          if (one_hot_s) state_d = ST_SETTLE;
          else           state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = {CW{1'b0}};
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // A digit switch landing during CAPTURE must not be lost in HOLD.
      ST_CAPTURE, ST_HOLD: begin
        cnt_d = {CW{1'b0}};
        if (anode_chg_s) begin
          if (one_hot_s) state_d = ST_SETTLE;
          else           state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture update of digit outputs, frame mask and error pulses.
  always_comb begin
    digits_d     = digits_q;
    valid_d      = valid_q;
    blank_d      = blank_q;
    mask_d       = mask_q;
    frame_done_d = 1'b0;
    err_seg_d    = 1'b0;
    err_anode_d  = multi_s && !prev_multi_s;
    if (cap_s) begin
      if (cap_dec_s[4]) begin
        digits_d[{cap_slot_s, 2'b00} +: 4] = cap_dec_s[3:0];
        valid_d[cap_slot_s] = 1'b1;
        blank_d[cap_slot_s] = 1'b0;
      end else if (cap_blank_s) begin
        blank_d[cap_slot_s] = 1'b1;
      end else begin
        err_seg_d = 1'b1;
      end
      if (mask_new_s == 4'hF) begin
        frame_done_d = 1'b1;
        mask_d       = 4'h0;
      end else begin
        mask_d = mask_new_s;
      end
    end else begin
      mask_d = mask_q;
    end
  end

  // Registered outputs and frame mask.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits_q     <= 16'h0000;
      valid_q      <= 4'h0;
      blank_q      <= 4'h0;
      mask_q       <= 4'h0;
      frame_done_q <= 1'b0;
      err_seg_q    <= 1'b0;
      err_anode_q  <= 1'b0;
    end else begin
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      blank_q      <= blank_d;
      mask_q       <= mask_d;
      frame_done_q <= frame_done_d;
      err_seg_q    <= err_seg_d;
      err_anode_q  <= err_anode_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign blank       = blank_q;
  assign frame_done  = frame_done_q;
  assign err_seg     = err_seg_q;
  assign err_anode   = err_anode_q;

`ifdef BLINK_DETECT_EN
  localparam int unsigned BW = (BLINK_WIN > 1) ? $clog2(BLINK_WIN) : 1;
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_WIN - 1);

  logic [3:0]         blink_q, blink_d, tog_q, tog_d, toggle_s;
  logic [3:0][BW-1:0] bcnt_q, bcnt_d;

  // Per-digit blink tracking: two blank/lit toggles inside the window mark blinking.
  always_comb begin
    blink_d = blink_q;
    tog_d   = tog_q;
    bcnt_d  = bcnt_q;
    for (int i = 0; i < 4; i++) begin
      toggle_s[i] = cap_s && (cap_slot_s == 2'(i)) &&
                    ((cap_dec_s[4] && blank_q[i]) || (cap_blank_s && !blank_q[i]));
      if (toggle_s[i]) begin
        bcnt_d[i] = {BW{1'b0}};
        if (tog_q[i]) blink_d[i] = 1'b1;
        else          tog_d[i]   = 1'b1;
      end else begin
        if (frame_done_q && (bcnt_q[i] != BCNT_LAST)) bcnt_d[i] = bcnt_q[i] + 1'b1;
        else                                          bcnt_d[i] = bcnt_q[i];
        if (bcnt_d[i] == BCNT_LAST) begin
          blink_d[i] = 1'b0;
          tog_d[i]   = 1'b0;
        end else begin
          blink_d[i] = blink_q[i];
        end
      end
    end
  end

  // Blink state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_q <= 4'h0;
      tog_q   <= 4'h0;
      bcnt_q  <= '0;
    end else begin
      blink_q <= blink_d;
      tog_q   <= tog_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign blinking = blink_q;
`else
  assign blinking = 4'b0000;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (default build, SETTLE_CYC=16).
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  anode_vec = 4'hF;
  logic [7:0]  cathode_vec = 8'hFF;
  logic [15:0] digits;
  logic [3:0]  digit_valid, blank, blinking;
  logic        frame_done, err_seg, err_anode;

  seg_scan_decoder #(.SETTLE_CYC(16), .BLINK_WIN(256)) dut (
    .clk(clk), .rst(rst), .anode_vec(anode_vec), .cathode_vec(cathode_vec),
    .digits(digits), .digit_valid(digit_valid), .blank(blank),
    .frame_done(frame_done), .err_seg(err_seg), .err_anode(err_anode),
    .blinking(blinking)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int fd_cnt  = 0;
  int es_cnt  = 0;
  int ea_cnt  = 0;

  // Count high cycles of each pulse output (value held before each edge).
  always @(posedge clk) begin
    if (rst) begin
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (err_seg)    es_cnt <= es_cnt + 1;
      if (err_anode)  ea_cnt <= ea_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Active-low cathode word (dp off) for a BCD digit.
  function automatic logic [7:0] cath_of(input int d);
    logic [6:0] seg;
    case (d)
      0: seg = 7'h3F; 1: seg = 7'h06; 2: seg = 7'h5B; 3: seg = 7'h4F;
      4: seg = 7'h66; 5: seg = 7'h6D; 6: seg = 7'h7D; 7: seg = 7'h07;
      8: seg = 7'h7F; 9: seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    return {1'b1, ~seg};
  endfunction

  task automatic drive_slot(input int idx, input logic [7:0] cath, input int ncyc);
    anode_vec   = ~(4'b0001 << idx);
    cathode_vec = cath;
    repeat (ncyc) @(negedge clk);
  endtask

  task automatic scan(input int d3, input int d2, input int d1, input int d0);
    drive_slot(3, cath_of(d3), 20);
    drive_slot(2, cath_of(d2), 20);
    drive_slot(1, cath_of(d1), 20);
    drive_slot(0, cath_of(d0), 20);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_digits"}, 32'(digits), 32'h0);
    check({pfx, "_valid"}, 32'(digit_valid), 32'h0);
    check({pfx, "_blank"}, 32'(blank), 32'h0);
    check({pfx, "_pulses"}, {29'd0, frame_done, err_seg, err_anode}, 32'h0);
    check({pfx, "_blinking"}, 32'(blinking), 32'h0);
  endtask

  int fd0, es0, ea0, lat;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Clean scan 1,2,5,9 with capture latency on the first slot
    fd0 = fd_cnt; es0 = es_cnt;
    anode_vec = 4'b0111; cathode_vec = cath_of(1);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (lat == 0 && digit_valid[3]) lat = c;
    end
    check("latency", lat, 19);
    drive_slot(2, cath_of(2), 20);
    drive_slot(1, cath_of(5), 20);
    drive_slot(0, cath_of(9), 20);
    check("scan1_fd", fd_cnt - fd0, 1);
    scan(1, 2, 5, 9);
    check("scan_digits", 32'(digits), 32'h1259);
    check("scan_valid", 32'(digit_valid), 32'hF);
    check("scan_blank", 32'(blank), 32'h0);
    check("scan_fd", fd_cnt - fd0, 2);
    check("scan_no_errseg", es_cnt - es0, 0);

    // Glitched slot 0: cathode bounces every 8 clk, no capture
    fd0 = fd_cnt;
    drive_slot(3, cath_of(1), 20);
    drive_slot(2, cath_of(2), 20);
    drive_slot(1, cath_of(5), 20);
    anode_vec = 4'b1110;
    for (int c = 0; c < 40; c++) begin
      cathode_vec = ((c % 8) == 7) ? cath_of(8) : cath_of(4);
      @(negedge clk);
    end
    check("glitch_fd", fd_cnt - fd0, 0);
    check("glitch_digits", 32'(digits), 32'h1259);
    drive_slot(0, cath_of(4), 20);
    check("clean_after_glitch_fd", fd_cnt - fd0, 1);
    check("clean_after_glitch_digits", 32'(digits), 32'h1254);

    // Unknown pattern 7'h49 on slot 0
    fd0 = fd_cnt; es0 = es_cnt;
    drive_slot(3, cath_of(1), 20);
    drive_slot(2, cath_of(2), 20);
    drive_slot(1, cath_of(5), 20);
    drive_slot(0, {1'b1, ~7'h49}, 20);
    check("errseg_pulse", es_cnt - es0, 1);
    check("errseg_digits", 32'(digits), 32'h1254);
    check("errseg_fd", fd_cnt - fd0, 1);

    // Multi-hot anode for 30 clk, then a clean scan
    fd0 = fd_cnt; ea0 = ea_cnt;
    anode_vec = 4'b0011; cathode_vec = cath_of(8);
    repeat (30) @(negedge clk);
    check("erranode_pulse", ea_cnt - ea0, 1);
    check("erranode_digits", 32'(digits), 32'h1254);
    check("erranode_fd", fd_cnt - fd0, 0);
    scan(3, 0, 4, 7);
    check("after_anode_digits", 32'(digits), 32'h3047);
    check("after_anode_fd", fd_cnt - fd0, 1);
    check("after_anode_ea", ea_cnt - ea0, 1);

    // Blank slot 0 keeps digit and valid, sets blank
    fd0 = fd_cnt;
    drive_slot(3, cath_of(3), 20);
    drive_slot(2, cath_of(0), 20);
    drive_slot(1, cath_of(4), 20);
    drive_slot(0, 8'hFF, 20);
    check("blank_flag", 32'(blank), 32'h1);
    check("blank_digits", 32'(digits), 32'h3047);
    check("blank_valid", 32'(digit_valid), 32'hF);
    check("blank_fd", fd_cnt - fd0, 1);
    scan(3, 0, 4, 2);
    check("unblank_flag", 32'(blank), 32'h0);
    check("unblank_digits", 32'(digits), 32'h3042);

    // Reset mid-SETTLE, then a full scan
    drive_slot(3, cath_of(6), 8);
    rst = 1'b0;
    #1;
    check_zero("midreset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    fd0 = fd_cnt;
    scan(1, 2, 5, 9);
    check("postreset_fd", fd_cnt - fd0, 1);
    check("postreset_digits", 32'(digits), 32'h1259);
    check("postreset_valid", 32'(digit_valid), 32'hF);
    check("blinking_off", 32'(blinking), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
